fp_int_to_float: RTL

- Iterative integer-to-single-precision converter that sits directly upstream of the FP adder.
- Turns a 32-bit signed or unsigned integer from the register file into an IEEE-754 single, so it can be fed as an FP add operand.
- Uses a start/busy/done handshake and normalises one bit per cycle.
- Rounds toward zero (truncation), matching the adder's no-rounding datapath.

---
 rtl/fp_int_to_float.sv | 89 ++++++++
 1 files changed

// File: rtl/fp_int_to_float.sv
// Iterative signed/unsigned 32-bit integer to IEEE-754 single converter.
// Normalises one bit per cycle and truncates (round toward zero).
module fp_int_to_float #(
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        unsigned_i,
  input  logic [31:0] int_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {StIdle, StNorm, StPack} state_e;

  localparam logic [7:0] ExpInit = 8'(EXP_BIAS + 32'd31);

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sign_d  = ~unsigned_i & int_i[31];
          // Signed 0x80000000 negates to itself, which is the correct magnitude.
          mag_d   = sign_d ? (~int_i + 32'd1) : int_i;
          zero_d  = (int_i == 32'd0);
          exp_d   = ExpInit;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (zero_q || mag_q[31]) begin
          state_d = StPack;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      StPack: begin
        // Hidden bit mag[31] is implied; mag[7:0] is dropped (truncation).
        result_d = zero_q ? 32'h0 : {sign_q, exp_q, mag_q[30:8]};
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mag_q    <= 32'h0;
      exp_q    <= 8'h0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
